// File: rtl/sha256_pkg.sv
// Shared SHA-256 padder definitions: FSM states, block/word geometry and the H_0 chaining value.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    // Initial hash value; the block processor selects it when first_block is set.
    localparam logic [255:0] H_0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        WAIT,
        PAD
    } pad_state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word formatter: keeps the first `bytes` bytes, writes 0x80 after them, zeroes the rest.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    input  logic [2:0]        bytes,
    output logic [WORD_W-1:0] word_out
);

    always_comb begin
        word_out = word_in;
        case (bytes)
            3'd0:    word_out = PAD_WORD;
            3'd1:    word_out = {word_in[31:24], 24'h80_0000};
            3'd2:    word_out = {word_in[31:16], 16'h8000};
            3'd3:    word_out = {word_in[31:8], 8'h80};
            default: word_out = word_in;
        endcase
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks with 0x80 and bit-length padding.
// Define SHA256_PADDER_PARTIAL_EN to honour in_bytes on the last word; otherwise every word is 4 bytes.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  in_data,
    input  logic [2:0]         in_bytes,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] M_out,
    output logic               M_valid,
    input  logic               blk_done,
    output logic               first_block,
    output logic               last_block
);

    pad_state_t state, state_n;
    logic [3:0] wcnt, wcnt_n;
    logic [LEN_W-1:0] len, len_n, len_acc;
    logic [0:BLOCK_WORDS-1][WORD_W-1:0] blk, blk_n;
    logic first_n, last_n;
    logic pad_pend, pad_pend_n;
    logic defer80, defer80_n;
    logic [2:0] eff_bytes;
    logic [WORD_W-1:0] padded;
    logic [63:0] len_field, len_field_acc;
    logic fits;

`ifdef SHA256_PADDER_PARTIAL_EN
    always_comb begin
        eff_bytes = 3'd4;
        if (in_last && in_bytes < 3'd4)
            eff_bytes = in_bytes;
    end
`else
    logic unused_bytes;
    assign unused_bytes = ^in_bytes;
    assign eff_bytes    = 3'd4;
`endif

    sha256_pad_word u_pad_word (
        .word_in  (in_data),
        .bytes    (eff_bytes),
        .word_out (padded)
    );

    assign len_acc       = len + LEN_W'({eff_bytes, 3'b000});
    assign len_field     = 64'(len);
    assign len_field_acc = 64'(len_acc);
    // A full last word needs one extra slot for 0x80 ahead of the two length words.
    assign fits          = (eff_bytes == 3'd4) ? (wcnt <= 4'd12) : (wcnt <= 4'd13);
    assign M_out         = blk;

    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        len_n      = len;
        blk_n      = blk;
        first_n    = first_block;
        last_n     = last_block;
        pad_pend_n = pad_pend;
        defer80_n  = defer80;
        in_ready   = 1'b0;
        M_valid    = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_n = len_acc;
                    if (!in_last) begin
                        blk_n[wcnt] = in_data;
                        if (wcnt == 4'd15) begin
                            state_n = EMIT;
                            last_n  = 1'b0;
                        end else begin
                            wcnt_n = wcnt + 4'd1;
                        end
                    end else begin
                        blk_n[wcnt] = padded;
                        for (int i = 0; i < BLOCK_WORDS; i++)
                            if (4'(i) > wcnt)
                                blk_n[i] = '0;
                        defer80_n = 1'b0;
                        if (eff_bytes == 3'd4) begin
                            if (wcnt != 4'd15)
                                blk_n[wcnt + 4'd1] = PAD_WORD;
                            else
                                defer80_n = 1'b1;
                        end
                        if (fits) begin
                            blk_n[14]  = len_field_acc[63:32];
                            blk_n[15]  = len_field_acc[31:0];
                            last_n     = 1'b1;
                            pad_pend_n = 1'b0;
                        end else begin
                            last_n     = 1'b0;
                            pad_pend_n = 1'b1;
                        end
                        state_n = EMIT;
                    end
                end
            end

            EMIT: begin
                M_valid = 1'b1;
                state_n = WAIT;
            end

            WAIT: begin
                if (blk_done) begin
                    state_n = pad_pend ? PAD : FILL;
                    wcnt_n  = '0;
                    first_n = last_block;
                    if (last_block) begin
                        len_n  = '0;
                        last_n = 1'b0;
                    end
                end
            end

            PAD: begin
                for (int i = 0; i < BLOCK_WORDS; i++)
                    blk_n[i] = '0;
                if (defer80)
                    blk_n[0] = PAD_WORD;
                blk_n[14]  = len_field[63:32];
                blk_n[15]  = len_field[31:0];
                last_n     = 1'b1;
                pad_pend_n = 1'b0;
                defer80_n  = 1'b0;
                state_n    = EMIT;
            end

            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wcnt        <= '0;
            len         <= '0;
            blk         <= '0;
            first_block <= 1'b1;
            last_block  <= 1'b0;
            pad_pend    <= 1'b0;
            defer80     <= 1'b0;
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            len         <= len_n;
            blk         <= blk_n;
            first_block <= first_n;
            last_block  <= last_n;
            pad_pend    <= pad_pend_n;
            defer80     <= defer80_n;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: table of whole messages plus hand sequences for hold, stray strobes and reset.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] M_out;
    logic         M_valid;
    logic         blk_done;
    logic         first_block;
    logic         last_block;

    int n_cmp = 0;
    int n_bad = 0;
    int done_dly = 1;
    int stray_cnt = 0;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_bytes    (in_bytes),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .M_out       (M_out),
        .M_valid     (M_valid),
        .blk_done    (blk_done),
        .first_block (first_block),
        .last_block  (last_block)
    );

    typedef struct {
        logic [511:0] m;
        logic         first;
        logic         last;
    } cap_t;

    typedef struct {
        string       name;
        int          nwords;
        logic [2:0]  last_bytes;
        logic [31:0] base;
        int          nblk;
        int          ndata;
        int          kw;
        logic [31:0] kv;
        logic [31:0] e14;
        logic [31:0] e15;
        logic [31:0] b1w0;
        logic [31:0] b1w15;
    } vec_t;

    cap_t cap_q[$];
    vec_t vecs[$];

    // Block monitor: records every emitted block.
    always @(negedge clk)
        if (M_valid)
            cap_q.push_back('{M_out, first_block, last_block});

    // Block-processor stand-in: answers each block after done_dly cycles, or fires a stray strobe on request.
    initial begin : responder
        int  stray_seen;
        bit  aborted;
        stray_seen = 0;
        blk_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                blk_done   = 1'b1;
                @(negedge clk);
                blk_done   = 1'b0;
            end else if (M_valid) begin
                aborted = 1'b0;
                for (int k = 0; k < done_dly; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    blk_done = 1'b1;
                    @(negedge clk);
                    blk_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic logic [511:0] exp_blk0(input vec_t v);
        logic [511:0] r;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < v.ndata)      w = v.base + 32'(i);
            else if (i == v.kw)   w = v.kv;
            else if (i == 14)     w = v.e14;
            else if (i == 15)     w = v.e15;
            else                  w = '0;
            r[511-32*i -: 32] = w;
        end
        return r;
    endfunction

    function automatic logic [511:0] exp_blk1(input vec_t v);
        logic [511:0] r;
        r = '0;
        r[511:480] = v.b1w0;
        r[31:0]    = v.b1w15;
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
        int n;
        n = 0;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int t;
        t = 0;
        while (cap_q.size() < n && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (cap_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL block_timeout: got %0d blocks want %0d", cap_q.size(), n);
        end
    endtask

    task automatic check_blocks(input vec_t v);
        cap_t c;
        wait_blocks(v.nblk);
        for (int b = 0; b < v.nblk; b++) begin
            if (cap_q.size() > 0) begin
                c = cap_q.pop_front();
                check({v.name, "_blk", (b == 0) ? "0" : "1"}, c.m, (b == 0) ? exp_blk0(v) : exp_blk1(v));
                check({v.name, "_flags", (b == 0) ? "0" : "1"}, 512'({c.first, c.last}),
                      512'({b == 0, b == v.nblk - 1}));
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.nwords; i++)
            send_word(v.base + 32'(i), i == v.nwords - 1, (i == v.nwords - 1) ? v.last_bytes : 3'd1);
        check({v.name, "_latency"}, 512'(M_valid), 512'(1));
        check_blocks(v);
    endtask

    initial begin : main
        vec_t         vx, vq, vs;
        logic [511:0] snap;
        int           bad_hold, t;
        bit           seen_done;

        //            name        nw  bytes  base          nblk ndata kw  kv            e14           e15           b1w0          b1w15
        vecs.push_back('{"one_full", 1, 3'd4, 32'h61626364, 1,  1,    1,  32'h80000000, 32'h0,        32'h20,       32'h0,        32'h0});
        vecs.push_back('{"b52",      13, 3'd4, 32'h10000000, 1, 13,   13,  32'h80000000, 32'h0,        32'h1A0,      32'h0,        32'h0});
        vecs.push_back('{"b56",      14, 3'd4, 32'h20000000, 2, 14,   -1,  32'h0,        32'h80000000, 32'h0,        32'h0,        32'h1C0});
        vecs.push_back('{"b60",      15, 3'd4, 32'h30000000, 2, 15,   -1,  32'h0,        32'h0,        32'h80000000, 32'h0,        32'h1E0});
        vecs.push_back('{"b64",      16, 3'd4, 32'h40000000, 2, 16,   -1,  32'h0,        32'h0,        32'h0,        32'h80000000, 32'h200});
`ifdef SHA256_PADDER_PARTIAL_EN
        vecs.push_back('{"abc",      1, 3'd3, 32'h61626300, 1,  0,    0,  32'h61626380, 32'h0,        32'h18,       32'h0,        32'h0});
        vecs.push_back('{"empty",    1, 3'd0, 32'hDEADBEEF, 1,  0,    0,  32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{"b54",      14, 3'd2, 32'h11223344, 1, 13,   13,  32'h11228000, 32'h0,        32'h1B0,      32'h0,        32'h0});
        vecs.push_back('{"b57",      15, 3'd1, 32'h11223344, 2, 14,   14,  32'h11800000, 32'h0,        32'h0,        32'h0,        32'h1C8});
        vecs.push_back('{"b63",      16, 3'd3, 32'h50000000, 2, 15,   15,  32'h50000080, 32'h0,        32'h0,        32'h0,        32'h1F8});
`else
        vecs.push_back('{"abc",      1, 3'd3, 32'h61626300, 1,  1,    1,  32'h80000000, 32'h0,        32'h20,       32'h0,        32'h0});
        vecs.push_back('{"empty",    1, 3'd0, 32'hDEADBEEF, 1,  1,    1,  32'h80000000, 32'h0,        32'h20,       32'h0,        32'h0});
        vecs.push_back('{"b54",      14, 3'd2, 32'h11223344, 2, 14,   -1,  32'h0,        32'h80000000, 32'h0,        32'h0,        32'h1C0});
        vecs.push_back('{"b57",      15, 3'd1, 32'h11223344, 2, 15,   -1,  32'h0,        32'h0,        32'h80000000, 32'h0,        32'h1E0});
        vecs.push_back('{"b63",      16, 3'd3, 32'h50000000, 2, 16,   -1,  32'h0,        32'h0,        32'h0,        32'h80000000, 32'h200});
`endif

        rst_n    = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_in_ready", 512'(in_ready), 512'(1));
        check("rst_m_valid", 512'(M_valid), 512'(0));
        check("rst_first", 512'(first_block), 512'(1));
        check("rst_last", 512'(last_block), 512'(0));
        check("rst_m_out", M_out, '0);

        foreach (vecs[i])
            run_vec(vecs[i]);

        // Slow block processor: M_out must hold and a waiting word must not be taken early.
        vx = '{"hold_x", 1, 3'd4, 32'hCAFEF00D, 1, 1, 1, 32'h80000000, 32'h0, 32'h20, 32'h0, 32'h0};
        vq = '{"hold_q", 1, 3'd4, 32'h0BADC0DE, 1, 1, 1, 32'h80000000, 32'h0, 32'h20, 32'h0, 32'h0};
        done_dly = 70;
        send_word(vx.base, 1'b1, 3'd4);
        check("hold_latency", 512'(M_valid), 512'(1));
        snap      = M_out;
        bad_hold  = 0;
        seen_done = 1'b0;
        t         = 0;
        in_data   = vq.base;
        in_last   = 1'b1;
        in_bytes  = 3'd4;
        in_valid  = 1'b1;
        while (!seen_done && t < 100) begin
            if (in_ready || M_out !== snap)
                bad_hold++;
            @(negedge clk); #1;
            t++;
            if (blk_done)
                seen_done = 1'b1;
        end
        done_dly = 1;
        check("hold_stable", 512'(bad_hold), 512'(0));
        check("hold_done_seen", 512'(seen_done), 512'(1));
        check("hold_ready_at_done", 512'(in_ready), 512'(0));
        @(negedge clk); #1;
        check("ready_after_done", 512'(in_ready), 512'(1));
        @(posedge clk);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("hold_q_latency", 512'(M_valid), 512'(1));
        check_blocks(vx);
        check_blocks(vq);

        // Stray blk_done in FILL mid-message must not disturb the word count.
        vs = '{"stray", 2, 3'd4, 32'h70000000, 1, 2, 2, 32'h80000000, 32'h0, 32'h40, 32'h0, 32'h0};
        send_word(vs.base, 1'b0, 3'd1);
        stray_cnt++;
        repeat (3) @(negedge clk);
        #1;
        send_word(vs.base + 32'd1, 1'b1, 3'd4);
        check("stray_latency", 512'(M_valid), 512'(1));
        check_blocks(vs);

        // Reset while waiting for the block processor.
        done_dly = 70;
        send_word(32'h12345678, 1'b1, 3'd4);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("wrst_m_valid", 512'(M_valid), 512'(0));
        check("wrst_first", 512'(first_block), 512'(1));
        check("wrst_last", 512'(last_block), 512'(0));
        check("wrst_m_out", M_out, '0);
        check("wrst_in_ready", 512'(in_ready), 512'(1));
        @(negedge clk); #1;
        rst_n    = 1'b1;
        done_dly = 1;
        cap_q.delete();
        @(negedge clk); #1;
        run_vec(vecs[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
